// File: rtl/serial_tx_pkg.sv
// Shared definitions for serial_tx: state encodings, line levels, width helper.
// SERIAL_TX_PARITY_EN widens the state to 3 bits and adds the PARITY state.
package serial_tx_pkg;

  // Ceiling log2, never below 1 so that counters always have at least one bit.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return (r == 0) ? 1 : r;
  endfunction

`ifdef SERIAL_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    PARITY = 3'd4
  } state_e;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;
`endif

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/serial_tx_baud_tick.sv
// Bit-period timer: modulo-CLKS_PER_BIT counter with synchronous clear.
// tick_o is high for the one cycle in which the count sits at CLKS_PER_BIT-1.
module baud_tick
  import serial_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic Clk,
  input  logic notReset,
  input  logic clear_i,
  output logic tick_o
);

  localparam int unsigned CNT_W = clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // Tick is registered from the next count so it lines up with cnt_q == LAST.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clear_i || (cnt_q == LAST)) cnt_d = '0;
    tick_d = (cnt_d == LAST);
  end

  always_ff @(posedge Clk or negedge notReset) begin
    if (!notReset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/serial_tx.sv
// Parallel-in serial-out framed transmitter: start, WIDTH data bits LSB-first,
// optional even parity (SERIAL_TX_PARITY_EN), stop. Each bit lasts CLKS_PER_BIT cycles.
module serial_tx
  import serial_tx_pkg::*;
#(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic             Clk,
  input  logic             notReset,
  input  logic [WIDTH-1:0] D,
  input  logic             Load,
  output logic             Ready,
  output logic             TxOut,
  output logic             Busy
);

  localparam int unsigned BIT_W = clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             tx_q, tx_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             accept_c;
  logic             tick;
`ifdef SERIAL_TX_PARITY_EN
  logic             parity_q, parity_d;
`endif

  assign accept_c = Load && ready_q;

  baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick (
    .Clk     (Clk),
    .notReset(notReset),
    .clear_i (accept_c),
    .tick_o  (tick)
  );

  // Next state, then line/handshake outputs derived from the next state so they register with it.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    tx_d      = LINE_IDLE;
`ifdef SERIAL_TX_PARITY_EN
    parity_d  = parity_q;
`endif

    case (state_q)
      IDLE: begin
        if (accept_c) begin
          state_d   = START;
          shift_d   = D;
          bit_cnt_d = '0;
`ifdef SERIAL_TX_PARITY_EN
          parity_d  = ^D;
`endif
        end
      end
      START: if (tick) state_d = DATA;
      DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == BIT_W'(WIDTH - 1)) begin
            bit_cnt_d = '0;
`ifdef SERIAL_TX_PARITY_EN
            state_d   = PARITY;
`else
            state_d   = STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      PARITY: if (tick) state_d = STOP;
`endif
      STOP: if (tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    case (state_d)
      START:   tx_d = START_BIT;
      DATA:    tx_d = shift_d[0];
`ifdef SERIAL_TX_PARITY_EN
      PARITY:  tx_d = parity_d;
`endif
      STOP:    tx_d = STOP_BIT;
      default: tx_d = LINE_IDLE;
    endcase

    ready_d = (state_d == IDLE);
    busy_d  = !ready_d;
  end

  always_ff @(posedge Clk or negedge notReset) begin
    if (!notReset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      tx_q      <= LINE_IDLE;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
`ifdef SERIAL_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign TxOut = tx_q;
  assign Ready = ready_q;
  assign Busy  = busy_q;

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: frame-level reference model feeds a scoreboard queue,
// a line monitor pops and checks every cycle of each observed frame.
module tb_serial_tx;

  localparam int WIDTH = 8;
  localparam int CPB   = 4;
`ifdef SERIAL_TX_PARITY_EN
  localparam int NBITS = WIDTH + 3;
`else
  localparam int NBITS = WIDTH + 2;
`endif
  localparam int FRAME_CYC = NBITS * CPB;

  typedef struct {
    logic [7:0] w;
    int         start;
  } exp_t;

  logic       Clk;
  logic       notReset;
  logic [7:0] D;
  logic       Load;
  logic       Ready;
  logic       TxOut;
  logic       Busy;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   model_busy = 0;
  int   n_pushed = 0;
  int   n_flushed = 0;
  int   frames_done = 0;
  int   frames_aborted = 0;
  bit   mon_active = 0;
  int   mon_cyc = 0;
  logic [7:0] mon_word = '0;

  serial_tx #(
    .WIDTH(WIDTH),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .Clk     (Clk),
    .notReset(notReset),
    .D       (D),
    .Load    (Load),
    .Ready   (Ready),
    .TxOut   (TxOut),
    .Busy    (Busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chkn(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Line level expected at bit slot idx of a frame carrying word w.
  function automatic logic bit_at(input logic [7:0] w, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= WIDTH) return w[idx-1];
`ifdef SERIAL_TX_PARITY_EN
    if (idx == WIDTH + 1) return ^w;
`endif
    return 1'b1;
  endfunction

  // Reference model: a word is taken when idle and Load is high; busy lasts one frame.
  always @(posedge Clk) begin
    cyc++;
    if (!notReset) begin
      model_busy = 0;
      n_flushed += q.size();
      q.delete();
    end else if (model_busy == 0) begin
      if (Load) begin
        q.push_back('{w: D, start: cyc});
        n_pushed++;
        model_busy = FRAME_CYC;
      end
    end else begin
      model_busy--;
    end
  end

  // Monitor: checks handshake outputs every cycle and the line against popped frames.
  always @(negedge Clk) begin
    exp_t e;
    if (!notReset) begin
      if (mon_active) frames_aborted++;
      mon_active = 0;
      chk1("rst_txout", TxOut, 1'b1);
      chk1("rst_ready", Ready, 1'b1);
      chk1("rst_busy", Busy, 1'b0);
    end else begin
      chk1("ready", Ready, model_busy == 0);
      chk1("busy", Busy, model_busy != 0);
      if (mon_active) begin
        chk1("txout", TxOut, bit_at(mon_word, mon_cyc / CPB));
        mon_cyc++;
        if (mon_cyc == FRAME_CYC) begin
          mon_active = 0;
          frames_done++;
        end
      end else if (TxOut == 1'b0) begin
        chk1("frame_expected", q.size() != 0, 1'b1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chkn("start_cycle", cyc, e.start);
          mon_word   = e.w;
          mon_active = 1;
          mon_cyc    = 1;
        end
      end else if (q.size() != 0) begin
        chk1("start_late", cyc <= q[0].start, 1'b1);
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 500 && model_busy != 0; i++) begin
      @(posedge Clk); #1;
    end
    if (model_busy != 0) chkn("idle_timeout", model_busy, 0);
  endtask

  task automatic wait_accepts(input int target);
    for (int i = 0; i < 200 && n_pushed < target; i++) begin
      @(posedge Clk); #1;
    end
    if (n_pushed < target) chkn("accept_timeout", n_pushed, target);
  endtask

  task automatic send(input logic [7:0] w);
    wait_idle();
    D = w;
    Load = 1'b1;
    @(posedge Clk); #1;
    Load = 1'b0;
    D = 8'($urandom);
  endtask

  initial begin
    int hold;
    notReset = 1'b0;
    Load = 1'b0;
    D = '0;
    repeat (3) @(posedge Clk);
    #1 notReset = 1'b1;

    // Idle line with Load low.
    repeat (20) @(posedge Clk);
    #1;

    send(8'hA5);
    send(8'h3C);
    // Load while busy must be ignored.
    repeat (10) begin @(posedge Clk); #1; end
    D = 8'hFF;
    Load = 1'b1;
    @(posedge Clk); #1;
    Load = 1'b0;
    D = 8'($urandom);
    wait_idle();
    repeat (8) begin @(posedge Clk); #1; end

    // Load held high: back-to-back frames.
    D = 8'h01;
    Load = 1'b1;
    wait_accepts(n_pushed + 1);
    D = 8'h80;
    wait_accepts(n_pushed + 1);
    Load = 1'b0;

    send(8'h07);

    // Abort during data bit 3 of 8'h0F.
    wait_idle();
    D = 8'h0F;
    Load = 1'b1;
    @(posedge Clk); #1;
    Load = 1'b0;
    repeat (16) @(posedge Clk);
    #2 notReset = 1'b0;
    #1;
    chk1("async_rst_txout", TxOut, 1'b1);
    chk1("async_rst_ready", Ready, 1'b1);
    chk1("async_rst_busy", Busy, 1'b0);
    repeat (3) @(posedge Clk);
    #1 notReset = 1'b1;
    repeat (30) begin @(posedge Clk); #1; end

    // Randomized Load pulses and holds with D changing underneath.
    for (int it = 0; it < 30; it++) begin
      Load = 1'b0;
      repeat ($urandom_range(0, 5)) begin @(posedge Clk); #1; end
      D = 8'($urandom);
      Load = 1'b1;
      hold = int'($urandom_range(1, 60));
      for (int c = 0; c < hold; c++) begin
        @(posedge Clk); #1;
        if ($urandom_range(0, 3) == 0) D = 8'($urandom);
      end
    end
    Load = 1'b0;

    wait_idle();
    repeat (5) begin @(posedge Clk); #1; end
    chkn("queue_drained", q.size(), 0);
    chkn("frame_accounting", frames_done + frames_aborted + n_flushed, n_pushed);
    chk1("monitor_idle", mon_active, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
